// File: rtl/cmd_queue_ring_v3_if.sv
// AXI4-Lite bundle for the ring pointer tracker; the master drives requests,
// the slave (cmd_queue_ring_v3) drives ready/response signals.
interface cmd_queue_ring_v3_if #(
  parameter int C_S_ADDR_WIDTH = 12
);
  logic [C_S_ADDR_WIDTH-1:0] awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [31:0]               wdata;
  logic [3:0]                wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [C_S_ADDR_WIDTH-1:0] araddr;
  logic                      arvalid;
  logic                      arready;
  logic [31:0]               rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/cmd_queue_ring_v3.sv
// Pointer, status and coalesced-interrupt tracker for C_NUM_CH rings behind one AXI4-Lite slave.
// Ring storage is external; only producer/consumer pointers and interrupt state live here.
module cmd_queue_ring_v3 #(
  parameter int C_S_ADDR_WIDTH = 12,
  parameter int C_NUM_CH       = 2,
  parameter int C_DEPTH_LOG2   = 4,
  parameter int C_TMO_WIDTH    = 16
) (
  input  logic                aclk,
  input  logic                areset,
  cmd_queue_ring_v3_if.slave  s_axi,
  output logic [C_NUM_CH-1:0] irq
);
  localparam int PW = C_DEPTH_LOG2 + 1;
  localparam int CW = C_S_ADDR_WIDTH - 5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] OFS_TAIL   = 3'd0;
  localparam logic [2:0] OFS_HEAD   = 3'd1;
  localparam logic [2:0] OFS_STATUS = 3'd2;
  localparam logic [2:0] OFS_CTRL   = 3'd3;
  localparam logic [2:0] OFS_IRQ    = 3'd4;

  localparam logic [PW-1:0] DEPTH_P = {1'b1, {C_DEPTH_LOG2{1'b0}}};

  logic                   awready_r;
  logic                   bvalid_r;
  logic [1:0]             bresp_r;
  logic                   arready_r;
  logic                   rvalid_r;
  logic [1:0]             rresp_r;
  logic [31:0]            rdata_r;
  logic [C_NUM_CH-1:0]    irq_r;

  logic [PW-1:0]          tail_r    [C_NUM_CH];
  logic [PW-1:0]          head_r    [C_NUM_CH];
  logic [PW-1:0]          pend_r    [C_NUM_CH];
  logic [C_TMO_WIDTH-1:0] timer_r   [C_NUM_CH];
  logic [C_TMO_WIDTH-1:0] tmo_r     [C_NUM_CH];
  logic [11:0]            thr_r     [C_NUM_CH];
  logic [C_NUM_CH-1:0]    en_r;
  logic [C_NUM_CH-1:0]    ovf_r;
  logic [C_NUM_CH-1:0]    unf_r;
  logic [C_NUM_CH-1:0]    ipend_r;

  logic [PW-1:0]          tail_nx_s  [C_NUM_CH];
  logic [PW-1:0]          head_nx_s  [C_NUM_CH];
  logic [PW-1:0]          pend_nx_s  [C_NUM_CH];
  logic [C_TMO_WIDTH-1:0] timer_nx_s [C_NUM_CH];
  logic [C_TMO_WIDTH-1:0] tmo_nx_s   [C_NUM_CH];
  logic [11:0]            thr_nx_s   [C_NUM_CH];
  logic [C_NUM_CH-1:0]    en_nx_s;
  logic [C_NUM_CH-1:0]    ovf_nx_s;
  logic [C_NUM_CH-1:0]    unf_nx_s;
  logic [C_NUM_CH-1:0]    ipend_nx_s;

  logic [PW-1:0]          occ_s      [C_NUM_CH];
  logic [PW-1:0]          delta_s    [C_NUM_CH];
  logic [PW-1:0]          pend_sum_s [C_NUM_CH];
  logic [31:0]            rd_word_s  [C_NUM_CH];
  logic [C_NUM_CH-1:0]    fire_s;
  logic [C_NUM_CH-1:0]    tail_ok_s;
  logic [C_NUM_CH-1:0]    head_ok_s;

  logic                   wr_hs_s;
  logic                   rd_hs_s;
  logic [CW-1:0]          wr_ch_s;
  logic [CW-1:0]          rd_ch_s;
  logic [2:0]             wr_ofs_s;
  logic [2:0]             rd_ofs_s;
  logic                   wr_map_s;
  logic                   rd_map_s;
  logic                   wr_rej_s;
  logic [PW-1:0]          wr_ptr_s;
  logic [C_TMO_WIDTH-1:0] wr_tmo_s;
  logic [31:0]            rd_data_s;
  logic                   unused_s;

  assign s_axi.awready = awready_r;
  assign s_axi.wready  = awready_r;
  assign s_axi.bvalid  = bvalid_r;
  assign s_axi.bresp   = bresp_r;
  assign s_axi.arready = arready_r;
  assign s_axi.rvalid  = rvalid_r;
  assign s_axi.rresp   = rresp_r;
  assign s_axi.rdata   = rdata_r;
  assign irq           = irq_r;

  assign wr_hs_s  = awready_r & s_axi.awvalid & s_axi.wvalid;
  assign rd_hs_s  = arready_r & s_axi.arvalid;
  assign wr_ch_s  = s_axi.awaddr[C_S_ADDR_WIDTH-1:5];
  assign rd_ch_s  = s_axi.araddr[C_S_ADDR_WIDTH-1:5];
  assign wr_ofs_s = s_axi.awaddr[4:2];
  assign rd_ofs_s = s_axi.araddr[4:2];
  // The channel field may be wide enough to hold C_NUM_CH itself, so compare in 32 bits.
  assign wr_map_s = (32'(wr_ch_s) < 32'(C_NUM_CH)) && (wr_ofs_s <= OFS_IRQ);
  assign rd_map_s = (32'(rd_ch_s) < 32'(C_NUM_CH)) && (rd_ofs_s <= OFS_IRQ);
  assign wr_ptr_s = s_axi.wdata[PW-1:0];
  assign wr_tmo_s = C_TMO_WIDTH'(s_axi.wdata[31:16]);
  assign unused_s = ^{s_axi.wstrb, s_axi.awaddr[1:0], s_axi.araddr[1:0], s_axi.wdata};

  generate
    for (genvar g = 0; g < C_NUM_CH; g++) begin : g_ch
      logic [11:0]   thr_eff_s;
      logic [PW-1:0] pend_base_s;
      logic [PW:0]   pend_add_s;

      assign occ_s[g]     = tail_r[g] - head_r[g];
      assign delta_s[g]   = wr_ptr_s - tail_r[g];
      assign tail_ok_s[g] = ((wr_ptr_s - head_r[g]) <= DEPTH_P) && (delta_s[g] <= (DEPTH_P - occ_s[g]));
      assign head_ok_s[g] = (tail_r[g] - wr_ptr_s) <= occ_s[g];

      assign thr_eff_s = (thr_r[g] == 12'd0) ? 12'd1 : thr_r[g];
      assign fire_s[g] = en_r[g] &&
                         ((13'(pend_r[g]) >= 13'(thr_eff_s)) ||
                          ((tmo_r[g] != {C_TMO_WIDTH{1'b0}}) && (pend_r[g] != {PW{1'b0}}) &&
                           (timer_r[g] == tmo_r[g])));

      // A fire consumes the old count; a same-cycle TAIL delta starts the next batch.
      assign pend_base_s   = fire_s[g] ? {PW{1'b0}} : pend_r[g];
      assign pend_add_s    = {1'b0, pend_base_s} + {1'b0, delta_s[g]};
      assign pend_sum_s[g] = pend_add_s[PW] ? {PW{1'b1}} : pend_add_s[PW-1:0];

      assign rd_word_s[g] =
        (rd_ofs_s == OFS_TAIL)   ? 32'(tail_r[g]) :
        (rd_ofs_s == OFS_HEAD)   ? 32'(head_r[g]) :
        (rd_ofs_s == OFS_STATUS) ? {6'd0, unf_r[g], ovf_r[g], 6'd0,
                                    (occ_s[g] == DEPTH_P), (occ_s[g] == {PW{1'b0}}), 16'(occ_s[g])} :
        (rd_ofs_s == OFS_CTRL)   ? {16'(tmo_r[g]), thr_r[g], 3'd0, en_r[g]} :
        (rd_ofs_s == OFS_IRQ)    ? {31'd0, ipend_r[g]} : 32'd0;
    end
  endgenerate

  // Select the addressed channel's read word; unmapped addresses are zeroed at capture.
  always_comb begin
    rd_data_s = 32'd0;
    for (int i = 0; i < C_NUM_CH; i++) begin
      rd_data_s = rd_data_s | ({32{rd_ch_s == CW'(i)}} & rd_word_s[i]);
    end
  end

  // Per-channel next state: coalescing timer/fire plus register writes.
  always_comb begin
    wr_rej_s   = 1'b0;
    en_nx_s    = en_r;
    ovf_nx_s   = ovf_r;
    unf_nx_s   = unf_r;
    ipend_nx_s = ipend_r | fire_s;
    for (int i = 0; i < C_NUM_CH; i++) begin
      tail_nx_s[i] = tail_r[i];
      head_nx_s[i] = head_r[i];
      thr_nx_s[i]  = thr_r[i];
      tmo_nx_s[i]  = tmo_r[i];
      pend_nx_s[i] = fire_s[i] ? {PW{1'b0}} : pend_r[i];
      if (fire_s[i] || (pend_r[i] == {PW{1'b0}}) || ipend_r[i]) begin
        timer_nx_s[i] = {C_TMO_WIDTH{1'b0}};
      end else if (timer_r[i] != {C_TMO_WIDTH{1'b1}}) begin
        timer_nx_s[i] = timer_r[i] + C_TMO_WIDTH'(1);
      end else begin
        timer_nx_s[i] = timer_r[i];
      end
      if (wr_hs_s && wr_map_s && (wr_ch_s == CW'(i))) begin
        case (wr_ofs_s)
          OFS_TAIL: begin
            if (tail_ok_s[i]) begin
              tail_nx_s[i] = wr_ptr_s;
              pend_nx_s[i] = pend_sum_s[i];
            end else begin
              ovf_nx_s[i] = 1'b1;
              wr_rej_s    = 1'b1;
            end
          end
          OFS_HEAD: begin
            if (head_ok_s[i]) begin
              head_nx_s[i] = wr_ptr_s;
            end else begin
              unf_nx_s[i] = 1'b1;
              wr_rej_s    = 1'b1;
            end
          end
          OFS_CTRL: begin
            en_nx_s[i]  = s_axi.wdata[0];
            thr_nx_s[i] = s_axi.wdata[15:4];
            tmo_nx_s[i] = wr_tmo_s;
          end
          OFS_IRQ: begin
            // A simultaneous fire keeps the pending bit set.
            if (s_axi.wdata[0] && !fire_s[i]) begin
              ipend_nx_s[i] = 1'b0;
            end else begin
              ipend_nx_s[i] = ipend_r[i] | fire_s[i];
            end
            if (s_axi.wdata[24]) begin
              ovf_nx_s[i] = 1'b0;
            end else begin
              ovf_nx_s[i] = ovf_r[i];
            end
            if (s_axi.wdata[25]) begin
              unf_nx_s[i] = 1'b0;
            end else begin
              unf_nx_s[i] = unf_r[i];
            end
          end
          default: ;
        endcase
      end else begin
        tail_nx_s[i] = tail_r[i];
      end
    end
  end

  // AXI handshake and response registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      awready_r <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rresp_r   <= RESP_OKAY;
      rdata_r   <= 32'd0;
    end else begin
      awready_r <= s_axi.awvalid & s_axi.wvalid & ~bvalid_r & ~awready_r;
      arready_r <= s_axi.arvalid & ~rvalid_r & ~arready_r;
      if (wr_hs_s) begin
        bvalid_r <= 1'b1;
        bresp_r  <= (wr_map_s && !wr_rej_s) ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi.bready) begin
        bvalid_r <= 1'b0;
      end
      if (rd_hs_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_map_s ? rd_data_s : 32'd0;
        rresp_r  <= rd_map_s ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi.rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  // Channel state and interrupt output registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        tail_r[i]  <= {PW{1'b0}};
        head_r[i]  <= {PW{1'b0}};
        pend_r[i]  <= {PW{1'b0}};
        timer_r[i] <= {C_TMO_WIDTH{1'b0}};
        tmo_r[i]   <= {C_TMO_WIDTH{1'b0}};
        thr_r[i]   <= 12'd0;
      end
      en_r    <= {C_NUM_CH{1'b0}};
      ovf_r   <= {C_NUM_CH{1'b0}};
      unf_r   <= {C_NUM_CH{1'b0}};
      ipend_r <= {C_NUM_CH{1'b0}};
      irq_r   <= {C_NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        tail_r[i]  <= tail_nx_s[i];
        head_r[i]  <= head_nx_s[i];
        pend_r[i]  <= pend_nx_s[i];
        timer_r[i] <= timer_nx_s[i];
        tmo_r[i]   <= tmo_nx_s[i];
        thr_r[i]   <= thr_nx_s[i];
      end
      en_r    <= en_nx_s;
      ovf_r   <= ovf_nx_s;
      unf_r   <= unf_nx_s;
      ipend_r <= ipend_nx_s;
      irq_r   <= ipend_nx_s & en_nx_s;
    end
  end
endmodule

// File: tb/tb_cmd_queue_ring_v3.sv
// Directed bench for cmd_queue_ring_v3 (2 channels, depth 16): pointer checks,
// wrap, threshold/timeout coalescing, unmapped accesses and mid-write reset.
module tb_cmd_queue_ring_v3;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic       aclk;
  logic       areset;
  logic [1:0] irq;
  int         n_cmp;
  int         n_err;
  logic       irq_n1;

  cmd_queue_ring_v3_if #(.C_S_ADDR_WIDTH(12)) s_axi ();

  cmd_queue_ring_v3 #(
    .C_S_ADDR_WIDTH(12),
    .C_NUM_CH(2),
    .C_DEPTH_LOG2(4),
    .C_TMO_WIDTH(16)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .s_axi(s_axi),
    .irq(irq)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge aclk);
    s_axi.awaddr  = a;
    s_axi.wdata   = d;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!s_axi.awready && n < 20);
    check("wr_awready", {31'd0, s_axi.awready}, 32'd1);
    @(negedge aclk);
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    irq_n1 = irq[0];
    check("wr_bvalid", {31'd0, s_axi.bvalid}, 32'd1);
    resp = s_axi.bresp;
    s_axi.bready = 1'b1;
    @(negedge aclk);
    s_axi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge aclk);
    s_axi.araddr  = a;
    s_axi.arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!s_axi.arready && n < 20);
    check("rd_arready", {31'd0, s_axi.arready}, 32'd1);
    @(negedge aclk);
    s_axi.arvalid = 1'b0;
    check("rd_rvalid", {31'd0, s_axi.rvalid}, 32'd1);
    d    = s_axi.rdata;
    resp = s_axi.rresp;
    s_axi.rready = 1'b1;
    @(negedge aclk);
    s_axi.rready = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [11:0] a, input logic [31:0] d,
                        input logic [1:0] exp_resp);
    logic [1:0] resp;
    axi_write(a, d, resp);
    check({tag, "_bresp"}, {30'd0, resp}, {30'd0, exp_resp});
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp_data,
                        input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  resp;
    axi_read(a, d, resp);
    check({tag, "_rdata"}, d, exp_data);
    check({tag, "_rresp"}, {30'd0, resp}, {30'd0, exp_resp});
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    irq_n1 = 1'b0;
    areset = 1'b1;
    s_axi.awaddr  = 12'h000;
    s_axi.awvalid = 1'b0;
    s_axi.wdata   = 32'd0;
    s_axi.wstrb   = 4'hF;
    s_axi.wvalid  = 1'b0;
    s_axi.bready  = 1'b0;
    s_axi.araddr  = 12'h000;
    s_axi.arvalid = 1'b0;
    s_axi.rready  = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_awready", {31'd0, s_axi.awready}, 32'd0);
    check("rst_arready", {31'd0, s_axi.arready}, 32'd0);
    check("rst_bvalid",  {31'd0, s_axi.bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, s_axi.rvalid},  32'd0);
    check("rst_irq",     {30'd0, irq},           32'd0);
    areset = 1'b0;

    rd_chk("status_reset", 12'h008, 32'h0001_0000, OKAY);
    check("irq_idle", {30'd0, irq}, 32'd0);

    // Basic pointer moves and underflow rejection
    wr_chk("tail5", 12'h000, 32'd5, OKAY);
    wr_chk("head3", 12'h004, 32'd3, OKAY);
    rd_chk("status_occ2", 12'h008, 32'h0000_0002, OKAY);
    wr_chk("head6_unf", 12'h004, 32'd6, SLVERR);
    rd_chk("status_unf", 12'h008, 32'h0200_0002, OKAY);
    rd_chk("head_kept", 12'h004, 32'd3, OKAY);
    wr_chk("clr_unf", 12'h010, 32'h0200_0000, OKAY);
    rd_chk("status_unf_clr", 12'h008, 32'h0000_0002, OKAY);

    // Fill, overflow and wrap
    do_reset();
    wr_chk("tail16", 12'h000, 32'd16, OKAY);
    rd_chk("status_full", 12'h008, 32'h0002_0010, OKAY);
    wr_chk("tail17_ovf", 12'h000, 32'd17, SLVERR);
    rd_chk("status_ovf", 12'h008, 32'h0102_0010, OKAY);
    rd_chk("tail_kept", 12'h000, 32'd16, OKAY);
    wr_chk("head16", 12'h004, 32'd16, OKAY);
    wr_chk("tail31", 12'h000, 32'h1F, OKAY);
    rd_chk("status_wrap", 12'h008, 32'h0100_000F, OKAY);

    // Threshold coalescing
    do_reset();
    wr_chk("ctrl_thr4", 12'h00C, 32'h0000_0041, OKAY);
    rd_chk("ctrl_rb", 12'h00C, 32'h0000_0041, OKAY);
    wr_chk("tail3", 12'h000, 32'd3, OKAY);
    repeat (3) @(negedge aclk);
    check("irq_below_thr", {31'd0, irq[0]}, 32'd0);
    wr_chk("tail4", 12'h000, 32'd4, OKAY);
    check("irq_thr_n1", {31'd0, irq_n1}, 32'd0);
    check("irq_thr_n2", {31'd0, irq[0]}, 32'd1);
    rd_chk("irq_reg", 12'h010, 32'h0000_0001, OKAY);
    wr_chk("tail5_keep", 12'h000, 32'd5, OKAY);
    check("irq_kept_by_ptr", {31'd0, irq[0]}, 32'd1);
    wr_chk("w1c_irq", 12'h010, 32'h0000_0001, OKAY);
    check("irq_w1c_n1", {31'd0, irq_n1}, 32'd0);
    check("irq_ch1_quiet", {31'd0, irq[1]}, 32'd0);

    // Timeout coalescing
    do_reset();
    wr_chk("ctrl_tmo10", 12'h00C, 32'h000A_0081, OKAY);
    wr_chk("tail1", 12'h000, 32'd1, OKAY);
    repeat (9) @(negedge aclk);
    check("irq_tmo_early", {31'd0, irq[0]}, 32'd0);
    @(negedge aclk);
    check("irq_tmo_fire", {31'd0, irq[0]}, 32'd1);

    // Unmapped channel/offset and second channel
    do_reset();
    wr_chk("wr_ch3", 12'h060, 32'd5, SLVERR);
    wr_chk("wr_ofs14", 12'h014, 32'd5, SLVERR);
    rd_chk("rd_ch3", 12'h060, 32'd0, SLVERR);
    rd_chk("rd_ofs14", 12'h014, 32'd0, SLVERR);
    rd_chk("ch0_tail_untouched", 12'h000, 32'd0, OKAY);
    wr_chk("ch1_tail9", 12'h020, 32'd9, OKAY);
    rd_chk("ch1_status", 12'h028, 32'h0000_0009, OKAY);
    rd_chk("ch0_status_empty", 12'h008, 32'h0001_0000, OKAY);

    // Reset asserted while a write response is outstanding
    @(negedge aclk);
    s_axi.awaddr  = 12'h000;
    s_axi.wdata   = 32'd7;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
    @(negedge aclk);
    check("midrst_awready", {31'd0, s_axi.awready}, 32'd1);
    @(negedge aclk);
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    check("midrst_bvalid_pre", {31'd0, s_axi.bvalid}, 32'd1);
    areset = 1'b1;
    #1;
    check("midrst_bvalid", {31'd0, s_axi.bvalid}, 32'd0);
    check("midrst_awready_low", {31'd0, s_axi.awready}, 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    rd_chk("midrst_tail0", 12'h000, 32'd0, OKAY);
    rd_chk("midrst_ch1_tail0", 12'h020, 32'd0, OKAY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
